// File: rtl/xip_read_cache.sv
// Direct-mapped one-word-per-line read cache sitting in front of the SPI APB
// controller; flash-window reads are served locally, everything else is forwarded.
module xip_read_cache #(
    parameter logic [31:0] flash_addr_start = 32'h30000000,
    parameter logic [31:0] flash_addr_end   = 32'h3fffffff,
    parameter int          lines            = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    input  logic        flush,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int IDX   = $clog2(lines);
    localparam int TAG_W = 22 - IDX;

    typedef enum logic [2:0] {
        IDLE, HIT, FILL_SETUP, FILL_ACCESS, PASS_SETUP, PASS_ACCESS, RESP, ERR
    } state_t;

    state_t             state;
    logic [lines-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [lines];
    logic [31:0]        data_mem [lines];
    logic               flush_pending;

    logic               setup;
    logic               in_window;
    logic [IDX-1:0]     lookup_idx;
    logic [TAG_W-1:0]   lookup_tag;
    logic               lookup_hit;
    logic [IDX-1:0]     fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               fill_done;
    logic               pass_write_done;
    logic               alloc;

    assign setup      = in_psel && !in_penable;
    assign in_window  = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
    // Bits above 23 never reach the flash, so they are left out of the tag.
    assign lookup_idx = in_paddr[IDX+1:2];
    assign lookup_tag = in_paddr[23:IDX+2];
    assign lookup_hit = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);

    // During a fill out_paddr already holds the word-aligned request address.
    assign fill_idx        = out_paddr[IDX+1:2];
    assign fill_tag        = out_paddr[23:IDX+2];
    assign fill_done       = (state == FILL_ACCESS) && out_pready;
    assign pass_write_done = (state == PASS_ACCESS) && out_pready && out_pwrite;
    assign alloc           = fill_done && !out_pslverr && !flush_pending && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            valid         <= '0;
            flush_pending <= 1'b0;
            hit_cnt       <= 32'd0;
            miss_cnt      <= 32'd0;
            out_psel      <= 1'b0;
            out_penable   <= 1'b0;
            out_paddr     <= 32'd0;
            out_pwdata    <= 32'd0;
            out_pwrite    <= 1'b0;
            out_pstrb     <= 4'd0;
            out_pprot     <= 3'd0;
            in_pready     <= 1'b0;
            in_pslverr    <= 1'b0;
            in_prdata     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        if (in_window && !in_pwrite) begin
                            if (lookup_hit) begin
                                state      <= HIT;
                                in_pready  <= 1'b1;
                                in_pslverr <= 1'b0;
                                in_prdata  <= data_mem[lookup_idx];
                            end else begin
                                state      <= FILL_SETUP;
                                out_psel   <= 1'b1;
                                out_paddr  <= {in_paddr[31:2], 2'b00};
                                out_pwrite <= 1'b0;
                                out_pwdata <= in_pwdata;
                                out_pstrb  <= in_pstrb;
                                out_pprot  <= in_pprot;
                            end
                        end else if (in_window) begin
                            state      <= ERR;
                            in_pready  <= 1'b1;
                            in_pslverr <= 1'b1;
                            in_prdata  <= 32'd0;
                        end else begin
                            state      <= PASS_SETUP;
                            out_psel   <= 1'b1;
                            out_paddr  <= in_paddr;
                            out_pwrite <= in_pwrite;
                            out_pwdata <= in_pwdata;
                            out_pstrb  <= in_pstrb;
                            out_pprot  <= in_pprot;
                        end
                    end
                end
                HIT: begin
                    in_pready <= 1'b0;
                    hit_cnt   <= hit_cnt + 32'd1;
                    state     <= IDLE;
                end
                FILL_SETUP, PASS_SETUP: begin
                    out_penable <= 1'b1;
                    state       <= (state == FILL_SETUP) ? FILL_ACCESS : PASS_ACCESS;
                end
                FILL_ACCESS, PASS_ACCESS: begin
                    if (out_pready) begin
                        out_psel    <= 1'b0;
                        out_penable <= 1'b0;
                        in_pready   <= 1'b1;
                        in_prdata   <= out_prdata;
                        in_pslverr  <= out_pslverr;
                        state       <= RESP;
                        if (state == FILL_ACCESS) miss_cnt <= miss_cnt + 32'd1;
                    end
                end
                RESP, ERR: begin
                    in_pready  <= 1'b0;
                    in_pslverr <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A register write may have reprogrammed the flash, so drop everything.
            if (flush || pass_write_done) valid <= '0;
            else if (alloc)               valid[fill_idx] <= 1'b1;

            if (state == IDLE)
                flush_pending <= 1'b0;
            else if (flush && (state == FILL_SETUP || state == FILL_ACCESS))
                flush_pending <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (alloc) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= out_prdata;
        end
    end
endmodule
